// File: rtl/serial_neg_pkg.sv
// Shared types for the two-requester bit-serial negator.
package serial_neg_pkg;

  localparam int NUM_REQ = 2;

  typedef logic req_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_twoscomp_core.sv
// Bit-serial two's-complement negator: pass bits through up to and
// including the first 1, invert every bit after it.
module serial_twoscomp_core (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  input  logic bit_in,
  output logic bit_out
);

  logic seen_q;
  logic seen_d;

  always_comb begin
    seen_d = seen_q;
    if (clear) begin
      seen_d = 1'b0;
    end else if (en && bit_in) begin
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= 1'b0;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign bit_out = seen_q ? ~bit_in : bit_in;

endmodule

// File: rtl/serial_neg_arb.sv
// Round-robin shared serial negator for two requesters.
// Optional ovf output enabled by SERIAL_NEG_OVF_FLAG_EN.
module serial_neg_arb
  import serial_neg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [WIDTH-1:0]   din0,
  input  logic [WIDTH-1:0]   din1,
  output logic [1:0]         ack,
  output logic               busy,
  output logic [WIDTH-1:0]   dout,
  output logic               dout_valid,
`ifdef SERIAL_NEG_OVF_FLAG_EN
  output logic               ovf,
`endif
  output logic               dout_id
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e               state_q, state_d;
  req_id_t              ptr_q, ptr_d;
  req_id_t              id_q, id_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  req_id_t              gnt;
  logic [WIDTH-1:0]     op;
  logic                 neg_clear;
  logic                 neg_en;
  logic                 neg_bit;
`ifdef SERIAL_NEG_OVF_FLAG_EN
  logic                 ovf_op_q, ovf_op_d;
`endif

  serial_twoscomp_core u_core (
    .clk     (clk),
    .reset   (reset),
    .clear   (neg_clear),
    .en      (neg_en),
    .bit_in  (shift_q[0]),
    .bit_out (neg_bit)
  );

  // Single requester wins outright; a tie goes to the pointer.
  always_comb begin
    gnt = ptr_q;
    unique case (1'b1)
      (req == 2'b01): gnt = 1'b0;
      (req == 2'b10): gnt = 1'b1;
      default:        gnt = ptr_q;
    endcase
  end

  assign op = gnt ? din1 : din0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    ack_d     = '0;
    shift_d   = shift_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    neg_clear = 1'b0;
    neg_en    = 1'b0;
`ifdef SERIAL_NEG_OVF_FLAG_EN
    ovf_op_d  = ovf_op_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d   = SHIFT;
          id_d      = gnt;
          ptr_d     = ~gnt;
          ack_d     = gnt ? 2'b10 : 2'b01;
          shift_d   = op;
          cnt_d     = '0;
          neg_clear = 1'b1;
`ifdef SERIAL_NEG_OVF_FLAG_EN
          ovf_op_d  = (op == MIN_NEG);
`endif
        end
      end
      SHIFT: begin
        neg_en  = 1'b1;
        shift_d = shift_q >> 1;
        res_d   = {neg_bit, res_q[WIDTH-1:1]};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ptr_q    <= 1'b0;
      id_q     <= 1'b0;
      ack_q    <= '0;
      shift_q  <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
`ifdef SERIAL_NEG_OVF_FLAG_EN
      ovf_op_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      ack_q    <= ack_d;
      shift_q  <= shift_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_NEG_OVF_FLAG_EN
      ovf_op_q <= ovf_op_d;
`endif
    end
  end

  assign ack        = ack_q;
  assign busy       = (state_q != IDLE);
  assign dout_valid = (state_q == DONE);
  assign dout       = res_q;
  assign dout_id    = id_q;
`ifdef SERIAL_NEG_OVF_FLAG_EN
  assign ovf        = dout_valid & ovf_op_q;
`endif

endmodule

// File: doc/serial_neg_arb.md
SERIAL_NEG_ARB -- requirements
Module: serial_neg_arb

Interface
REQ-001 Parameter: WIDTH, 8, operand width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  clock, rising edge.
REQ-003 Port: reset  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  2  per-requester level request; bit i = requester i.
REQ-005 Port: din0  input  WIDTH  requester 0 operand, two's complement.
REQ-006 Port: din1  input  WIDTH  requester 1 operand, two's complement.
REQ-007 Port: ack  output  2  one-hot, one-cycle pulse; operand of requester i captured.
REQ-008 Port: busy  output  1  high while an operation is in flight (SHIFT or DONE).
REQ-009 Port: dout  output  WIDTH  negated operand (-din mod 2^WIDTH); valid only with dout_valid.
REQ-010 Port: dout_valid  output  1  one-cycle result strobe.
REQ-011 Port: dout_id  output  1  requester owning dout; valid only with dout_valid.

Function
REQ-012 The block SHALL share one bit-serial two's-complement negator between two requesters, using FSM states IDLE, SHIFT and DONE.
REQ-013 IDLE: if any req bit is high at an edge, the block SHALL perform four actions at that edge E0.
- Grant one requester.
- Load its din into the shift register.
- Clear the bit counter and the negator state.
- Pulse the matching ack bit in the following cycle and enter SHIFT.
REQ-014 Arbitration SHALL be round-robin with a 1-bit priority pointer.
- A single requester is always granted.
- When both request, the pointer's requester is granted.
- The pointer flips to the non-granted requester on every grant.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, processing one bit per cycle LSB-first.
- The negator outputs in while no 1 has been seen.
- After the first 1 has been consumed, it outputs ~in.
- Each result bit is shifted into the result register from the MSB end.
REQ-016 At edge E0+WIDTH the FSM SHALL enter DONE; dout_valid SHALL be high for exactly that one cycle with dout and dout_id stable; FSM then returns to IDLE.
REQ-017 Earliest next capture SHALL be edge E0+WIDTH+2; throughput is one operation per WIDTH+2 cycles.
REQ-018 Requests and din changes during SHIFT or DONE SHALL be ignored; the operand is sampled only at E0.
REQ-019 A requester still requesting after its ack is treated as a new request and SHALL be arbitrated normally.
REQ-020 Boundary results SHALL be as follows.
- din=0 gives dout=0.
- din=2^(WIDTH-1) gives dout=2^(WIDTH-1).
- din=all-ones gives dout=1.

Reset
REQ-021 Reset SHALL force the following state: FSM=IDLE, priority pointer=0, ack=0, busy=0, dout_valid=0, dout=0, dout_id=0, and cleared shift, result and counter registers.
REQ-022 Reset asserted mid-SHIFT or in DONE SHALL abort the operation with no dout_valid; there is no later completion.
REQ-023 The first request after reset deassertion SHALL be arbitrated normally at the first edge with reset low.

Configuration
REQ-024 Macro SERIAL_NEG_OVF_FLAG_EN defined: the block SHALL add an output port ovf (1 bit), which is high with dout_valid iff the captured operand equals 2^(WIDTH-1), and 0 otherwise and at reset.
REQ-025 Macro SERIAL_NEG_OVF_FLAG_EN undefined: the ovf port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-026 Package serial_neg_pkg SHALL hold the FSM state enum (IDLE/SHIFT/DONE), the requester-id typedef and the requester count constant (2).
REQ-027 The negator SHALL be the sub-module serial_twoscomp_core.
- Inputs: clk, reset, clear, en, bit_in.
- Output: bit_out, combinational from bit_in and the seen-one flag.
- The seen-one flag sets on en & bit_in and clears on clear or reset.

Verification (WIDTH=8)
REQ-028 Apply req=01, din0=0x05. Required: ack=01 for one cycle, then dout=0xFB, dout_id=0, and dout_valid exactly 8 cycles after ack.
REQ-029 Apply req=11 held with din0=0x01 and din1=0x03. Required: grants alternate 0,1,0; results are 0xFF(id0), 0xFD(id1), 0xFF(id0), spaced 10 cycles apart.
REQ-030 Apply din1=0x80 alone. Required: dout=0x80; with SERIAL_NEG_OVF_FLAG_EN defined, ovf=1. Then apply din1=0x00. Required: dout=0x00, ovf=0.
REQ-031 Assert reset 3 cycles into SHIFT (din0=0x2A). Required: no dout_valid, busy=0 the cycle after reset. A following req=01 with din0=0x2A gives 0xD6.
REQ-032 Apply req=01 with din0=0x7F, then change din0 to 0x00 and raise req bit 1 during SHIFT. Required: dout=0x81, id0; requester 1 is granted next.
